// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
//   state_t  : sequencer FSM encoding (also exported on the debug `state` port)
//   RELOCK_W : width of the saturating PLL re-reset counter
package pll_reset_pkg;

    localparam int unsigned RELOCK_W = 8;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST     = 3'd0,
        WAIT_LOCK   = 3'd1,
        STABLE      = 3'd2,
        RELEASE_SYS = 3'd3,
        RUN         = 3'd4
    } state_t;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit.
//   clk     : destination clock
//   reset_n : synchronous active-low reset, clears both stages to 0
//   d       : asynchronous input
//   q       : synchronized output (2-cycle latency)
module bit_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases the system
// reset followed by the peripheral reset. Loss of lock or a lock timeout
// re-resets the PLL.
//   clk            : reference clock (same clock as the PLL refclk)
//   reset_n        : synchronous active-low reset
//   pll_locked     : raw PLL lock, asynchronous to clk
//   pll_rst        : active-high PLL reset
//   sys_reset_n    : active-low system reset
//   periph_reset_n : active-low peripheral reset
//   relock_count   : saturating count of PLL re-reset events
//   state          : current FSM state (debug)
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 32,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RELEASE_GAP        = 16,
    parameter int unsigned LOCK_TIMEOUT       = 1000000,
    parameter int unsigned CNT_W              = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                sys_reset_n,
    output logic                periph_reset_n,
    output logic [RELOCK_W-1:0] relock_count,
    output logic [STATE_W-1:0]  state
);

    // Terminal counts: cnt is 0 on the first edge spent in a state.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
    // The WAIT_LOCK sample that enters STABLE is the first of the run, so
    // STABLE itself needs LOCK_STABLE_CYCLES-1 further samples.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYCLES > 1) ? (LOCK_STABLE_CYCLES - 2) : 32'd0);
    localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RELOCK_W-1:0]   relock_q, relock_d;
    logic                  init_q, init_d;
    logic                  pll_rst_q, pll_rst_d;
    logic                  sys_q, sys_d;
    logic                  periph_q, periph_d;
    logic                  relock_inc;
    logic                  locked_s;

    bit_sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    // Next state, shared counter, relock counter and registered outputs.
    always_comb begin
        state_d    = state_q;
        // The first edge out of reset re-enters PLL_RST, so the hold time
        // counts from that edge.
        cnt_d      = init_q ? '0 : cnt_q + CNT_W'(1);
        relock_d   = relock_q;
        relock_inc = 1'b0;
        init_d     = 1'b0;

        case (state_q)
            PLL_RST: begin
                if (!init_q && cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = (LOCK_STABLE_CYCLES <= 1) ? RELEASE_SYS : STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = PLL_RST;
                    relock_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s)                  state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = RELEASE_SYS;
            end
            RELEASE_SYS: begin
                // Loss of lock wins over gap expiry.
                if (!locked_s) begin
                    state_d    = PLL_RST;
                    relock_inc = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d    = PLL_RST;
                    relock_inc = 1'b1;
                end
            end
            default: state_d = PLL_RST;
        endcase

        if (state_d != state_q) cnt_d = '0;

        if (relock_inc && relock_q != RELOCK_MAX) relock_d = relock_q + RELOCK_W'(1);

        pll_rst_d = (state_d == PLL_RST);
        sys_d     = (state_d == RELEASE_SYS) || (state_d == RUN);
        periph_d  = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            relock_q  <= '0;
            init_q    <= 1'b1;
            pll_rst_q <= 1'b1;
            sys_q     <= 1'b0;
            periph_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            relock_q  <= relock_d;
            init_q    <= init_d;
            pll_rst_q <= pll_rst_d;
            sys_q     <= sys_d;
            periph_q  <= periph_d;
        end
    end

    assign pll_rst        = pll_rst_q;
    assign sys_reset_n    = sys_q;
    assign periph_reset_n = periph_q;
    assign relock_count   = relock_q;
    assign state          = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expected output
// snapshots tagged with an absolute clock-edge number; a negedge monitor
// pops and compares them when that edge has been reached.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       periph_reset_n;
    logic [7:0] relock_count;
    logic [2:0] state;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .RELEASE_GAP        (3),
        .LOCK_TIMEOUT       (50),
        .CNT_W              (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .pll_rst        (pll_rst),
        .sys_reset_n    (sys_reset_n),
        .periph_reset_n (periph_reset_n),
        .relock_count   (relock_count),
        .state          (state)
    );

    typedef struct packed {
        int unsigned cyc;
        logic [13:0] val;   // {pll_rst, sys_reset_n, periph_reset_n, relock_count, state}
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int unsigned cyc;
    int          checks;
    int          errors;
    logic        done;
    logic        flushed;
    exp_t        cur;
    string       cur_name;
    logic [13:0] got;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of posedges seen so far.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        checks  = 0;
        errors  = 0;
        flushed = 1'b0;
    end

    // Monitor: compare every expectation due at this edge.
    always @(negedge clk) begin
        got = {pll_rst, sys_reset_n, periph_reset_n, relock_count, state};
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            cur      = exp_q.pop_front();
            cur_name = name_q.pop_front();
            checks   = checks + 1;
            if (cur.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s: edge %0d skipped, now at %0d", cur_name, cur.cyc, cyc);
            end else if (got !== cur.val) begin
                errors = errors + 1;
                $display("FAIL %s @%0d: got pr=%b sr=%b pe=%b rc=%0d st=%0d, want pr=%b sr=%b pe=%b rc=%0d st=%0d",
                         cur_name, cyc, got[13], got[12], got[11], got[10:3], got[2:0],
                         cur.val[13], cur.val[12], cur.val[11], cur.val[10:3], cur.val[2:0]);
            end
        end
        if (done && !flushed) begin
            while (exp_q.size() != 0) begin
                cur      = exp_q.pop_front();
                cur_name = name_q.pop_front();
                checks   = checks + 1;
                errors   = errors + 1;
                $display("FAIL %s: edge %0d never reached", cur_name, cur.cyc);
            end
            flushed = 1'b1;
        end
    end

    task automatic expect_at(input int unsigned c, input string nm, input logic pr,
                             input logic sr, input logic pe, input logic [7:0] rc,
                             input logic [2:0] st);
        exp_t e;
        e.cyc = c;
        e.val = {pr, sr, pe, rc, st};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Return #1 after edge k.
    task automatic wait_to(input int unsigned k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int unsigned n, output int unsigned e0);
        int unsigned k;
        k       = cyc;
        reset_n = 1'b0;
        expect_at(k + n, "reset_values", 1'b1, 1'b0, 1'b0, 8'd0, 3'd0);
        wait_to(k + n);
        reset_n = 1'b1;
        e0      = k + n + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        int unsigned u;
        done       = 1'b0;
        reset_n    = 1'b0;
        pll_locked = 1'b0;

        // Power-up: lock first sampled at e0+10 and held.
        do_reset(3, e0);
        expect_at(e0 + 3,  "pwr_rst_held",    1'b1, 1'b0, 1'b0, 8'd0, 3'd0);
        expect_at(e0 + 4,  "pwr_rst_fall",    1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
        expect_at(e0 + 11, "pwr_sync_delay",  1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
        expect_at(e0 + 12, "pwr_stable",      1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
        expect_at(e0 + 18, "pwr_sys_held",    1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
        expect_at(e0 + 19, "pwr_sys_rel",     1'b0, 1'b1, 1'b0, 8'd0, 3'd3);
        expect_at(e0 + 21, "pwr_per_held",    1'b0, 1'b1, 1'b0, 8'd0, 3'd3);
        expect_at(e0 + 22, "pwr_per_rel",     1'b0, 1'b1, 1'b1, 8'd0, 3'd4);
        wait_to(e0 + 9);
        pll_locked = 1'b1;
        wait_to(e0 + 22);

        // Loss of lock in RUN, then lock returns.
        pll_locked = 1'b0;
        u = cyc + 1;
        expect_at(u + 1,  "loss_still_run",   1'b0, 1'b1, 1'b1, 8'd0, 3'd4);
        expect_at(u + 2,  "loss_all_reset",   1'b1, 1'b0, 1'b0, 8'd1, 3'd0);
        expect_at(u + 5,  "loss_rst_held",    1'b1, 1'b0, 1'b0, 8'd1, 3'd0);
        expect_at(u + 6,  "loss_wait_lock",   1'b0, 1'b0, 1'b0, 8'd1, 3'd1);
        expect_at(u + 7,  "loss_stable",      1'b0, 1'b0, 1'b0, 8'd1, 3'd2);
        expect_at(u + 13, "loss_sys_held",    1'b0, 1'b0, 1'b0, 8'd1, 3'd2);
        expect_at(u + 14, "loss_sys_rel",     1'b0, 1'b1, 1'b0, 8'd1, 3'd3);
        expect_at(u + 17, "loss_per_rel",     1'b0, 1'b1, 1'b1, 8'd1, 3'd4);
        wait_to(u + 2);
        pll_locked = 1'b1;
        wait_to(u + 17);

        // Mid-run reset for one cycle, lock held throughout.
        do_reset(1, e0);
        expect_at(e0 + 3,  "mid_rst_held",    1'b1, 1'b0, 1'b0, 8'd0, 3'd0);
        expect_at(e0 + 4,  "mid_wait_lock",   1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
        expect_at(e0 + 5,  "mid_stable",      1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
        expect_at(e0 + 11, "mid_sys_held",    1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
        expect_at(e0 + 12, "mid_sys_rel",     1'b0, 1'b1, 1'b0, 8'd0, 3'd3);
        expect_at(e0 + 14, "mid_per_held",    1'b0, 1'b1, 1'b0, 8'd0, 3'd3);
        expect_at(e0 + 15, "mid_per_rel",     1'b0, 1'b1, 1'b1, 8'd0, 3'd4);
        wait_to(e0 + 15);

        // Unstable lock: high 5, low 2, then high.
        pll_locked = 1'b0;
        do_reset(3, e0);
        expect_at(e0 + 16, "unst_run5",       1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
        expect_at(e0 + 17, "unst_drop",       1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
        expect_at(e0 + 18, "unst_low2",       1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
        expect_at(e0 + 19, "unst_restart",    1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
        expect_at(e0 + 25, "unst_sys_held",   1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
        expect_at(e0 + 26, "unst_sys_rel",    1'b0, 1'b1, 1'b0, 8'd0, 3'd3);
        expect_at(e0 + 29, "unst_per_rel",    1'b0, 1'b1, 1'b1, 8'd0, 3'd4);
        wait_to(e0 + 9);
        pll_locked = 1'b1;
        wait_to(e0 + 14);
        pll_locked = 1'b0;
        wait_to(e0 + 16);
        pll_locked = 1'b1;
        wait_to(e0 + 29);

        // Lock timeout and relock_count saturation, lock never arrives.
        pll_locked = 1'b0;
        do_reset(3, e0);
        expect_at(e0 + 4,     "to_wait_lock",  1'b0, 1'b0, 1'b0, 8'd0,   3'd1);
        expect_at(e0 + 53,    "to_before",     1'b0, 1'b0, 1'b0, 8'd0,   3'd1);
        expect_at(e0 + 54,    "to_relock1",    1'b1, 1'b0, 1'b0, 8'd1,   3'd0);
        expect_at(e0 + 57,    "to_rst_held",   1'b1, 1'b0, 1'b0, 8'd1,   3'd0);
        expect_at(e0 + 58,    "to_wait2",      1'b0, 1'b0, 1'b0, 8'd1,   3'd1);
        expect_at(e0 + 107,   "to_before2",    1'b0, 1'b0, 1'b0, 8'd1,   3'd1);
        expect_at(e0 + 108,   "to_relock2",    1'b1, 1'b0, 1'b0, 8'd2,   3'd0);
        expect_at(e0 + 13769, "sat_254",       1'b0, 1'b0, 1'b0, 8'd254, 3'd1);
        expect_at(e0 + 13770, "sat_255",       1'b1, 1'b0, 1'b0, 8'd255, 3'd0);
        expect_at(e0 + 13824, "sat_no_wrap",   1'b1, 1'b0, 1'b0, 8'd255, 3'd0);
        expect_at(e0 + 14040, "sat_260",       1'b1, 1'b0, 1'b0, 8'd255, 3'd0);
        expect_at(e0 + 14044, "sat_wait",      1'b0, 1'b0, 1'b0, 8'd255, 3'd1);
        wait_to(e0 + 14046);

        done = 1'b1;
        while (!flushed) begin
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
